// File: rtl/stop_detector.sv
// Threshold stop detector: arms on start, flags the first exact match of a valid accumulator
// sample against threshold, and forces a finish after TIMEOUT counted cycles.
module stop_detector #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             acc_valid,
    input  logic [WIDTH-1:0] acc_val,
    input  logic [WIDTH-1:0] threshold,
    output logic             stop_flag,
    output logic             stop_pulse,
    output logic             finish,
    output logic [15:0]      hit_cycle,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StArmed    = 2'd1,
        StStopped  = 2'd2,
        StFinished = 2'd3
    } state_e;

    localparam logic [15:0] LastCnt = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        stop_flag_q;
    logic        stop_pulse_q;
    logic        finish_q;
    logic [15:0] hit_cycle_q;

    logic match_now;
    logic timeout_now;

    // Only meaningful while counting; the FSM decides whether it is acted on.
    assign match_now   = acc_valid && (acc_val == threshold);
    assign timeout_now = (cnt_q == LastCnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            stop_flag_q  <= 1'b0;
            stop_pulse_q <= 1'b0;
            finish_q     <= 1'b0;
            hit_cycle_q  <= '0;
        end else if (clear) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            stop_flag_q  <= 1'b0;
            stop_pulse_q <= 1'b0;
            finish_q     <= 1'b0;
            hit_cycle_q  <= '0;
        end else begin
            stop_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StArmed;
                        cnt_q   <= '0;
                    end
                end
                StArmed: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (match_now) begin
                        stop_flag_q  <= 1'b1;
                        stop_pulse_q <= 1'b1;
                        hit_cycle_q  <= cnt_q;
                        state_q      <= StStopped;
                    end
                    // Timeout wins the state even when a match lands on the same edge.
                    if (timeout_now) begin
                        finish_q <= 1'b1;
                        state_q  <= StFinished;
                    end
                end
                StStopped: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (timeout_now) begin
                        finish_q <= 1'b1;
                        state_q  <= StFinished;
                    end
                end
                StFinished: begin
                    state_q <= StFinished;
                end
            endcase
        end
    end

    assign stop_flag  = stop_flag_q;
    assign stop_pulse = stop_pulse_q;
    assign finish     = finish_q;
    assign hit_cycle  = hit_cycle_q;
    assign state      = state_q;

endmodule

// File: tb/tb_stop_detector.sv
// Scoreboard bench for stop_detector: a driver pushes model predictions, a monitor pops and
// compares them one clock later; directed scenarios are followed by randomized traffic.
module tb_stop_detector;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic             acc_valid = 1'b0;
    logic [WIDTH-1:0] acc_val = '0;
    logic [WIDTH-1:0] threshold = '0;
    logic             stop_flag;
    logic             stop_pulse;
    logic             finish;
    logic [15:0]      hit_cycle;
    logic [1:0]       state;

    stop_detector #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .acc_valid (acc_valid),
        .acc_val   (acc_val),
        .threshold (threshold),
        .stop_flag (stop_flag),
        .stop_pulse(stop_pulse),
        .finish    (finish),
        .hit_cycle (hit_cycle),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        flag;
        logic        pulse;
        logic        fin;
        logic [15:0] hit;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: the run is described by three facts (running, matched, timed out)
    bit m_running = 0;
    bit m_matched = 0;
    bit m_timed   = 0;
    int m_cycles  = 0;
    bit m_pulse   = 0;
    int m_hit     = 0;

    function automatic exp_t model_step(bit r, bit c, bit s, bit v, int unsigned val,
                                        int unsigned thr);
        exp_t e;
        if (!r || c) begin
            m_running = 0; m_matched = 0; m_timed = 0;
            m_cycles = 0; m_pulse = 0; m_hit = 0;
        end else begin
            m_pulse = 0;
            if (!m_running && !m_timed) begin
                if (s) begin
                    m_running = 1;
                    m_cycles  = 0;
                end
            end else if (m_running) begin
                if (!m_matched && v && val == thr) begin
                    m_matched = 1;
                    m_pulse   = 1;
                    m_hit     = m_cycles;
                end
                if (m_cycles == TIMEOUT - 1) begin
                    m_timed   = 1;
                    m_running = 0;
                end
                m_cycles++;
            end
        end
        e.flag  = m_matched;
        e.pulse = m_pulse;
        e.fin   = m_timed;
        e.hit   = 16'(m_hit);
        e.st    = m_timed ? 2'd3 : (m_matched ? 2'd2 : (m_running ? 2'd1 : 2'd0));
        return e;
    endfunction

    task automatic cyc(bit r, bit c, bit s, bit v, int unsigned val, int unsigned thr);
        @(negedge clk);
        rst_n     = r;
        clear     = c;
        start     = s;
        acc_valid = v;
        acc_val   = WIDTH'(val);
        threshold = WIDTH'(thr);
        exp_q.push_back(model_step(r, c, s, v, val, thr));
    endtask

    task automatic idle_cyc();
        cyc(1, 0, 0, 0, 0, 100);
    endtask

    // Directed spot checks against fixed expectations, sampled after the pending edge.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: one registered output set per clock, compared against the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                exp_t got;
                e         = exp_q.pop_front();
                got.flag  = stop_flag;
                got.pulse = stop_pulse;
                got.fin   = finish;
                got.hit   = hit_cycle;
                got.st    = state;
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got flag=%b pulse=%b fin=%b hit=%0d st=%0d, expected flag=%b pulse=%b fin=%b hit=%0d st=%0d",
                             $time, got.flag, got.pulse, got.fin, got.hit, got.st,
                             e.flag, e.pulse, e.fin, e.hit, e.st);
                end
            end
        end
    end

    initial begin
        // Reset
        cyc(0, 0, 0, 0, 0, 100);
        cyc(0, 0, 1, 1, 100, 100);
        settle();
        chk("reset_state", int'(state), 0);
        chk("reset_flags", int'({stop_flag, stop_pulse, finish}), 0);

        // Normal stop at the 11th sample
        cyc(1, 0, 1, 0, 0, 100);
        for (int i = 0; i <= 10; i++) cyc(1, 0, 0, 1, 10 * i, 100);
        settle();
        chk("stop_pulse", int'(stop_pulse), 1);
        chk("stop_flag", int'(stop_flag), 1);
        chk("stop_hit", int'(hit_cycle), 10);
        chk("stop_state", int'(state), 2);
        cyc(1, 0, 0, 1, 100, 100);
        settle();
        chk("pulse_one_cycle", int'(stop_pulse), 0);
        chk("hit_held", int'(hit_cycle), 10);

        // Timeout with no match
        cyc(1, 1, 0, 0, 0, 100);
        cyc(1, 0, 1, 0, 0, 100);
        for (int i = 0; i < 19; i++) cyc(1, 0, 0, 1, 0, 100);
        settle();
        chk("armed_before_timeout", int'(state), 1);
        cyc(1, 0, 0, 1, 0, 100);
        settle();
        chk("timeout_state", int'(state), 3);
        chk("timeout_finish", int'(finish), 1);
        chk("timeout_noflag", int'(stop_flag), 0);

        // Stop at counter 5, then timeout
        cyc(1, 1, 0, 0, 0, 100);
        cyc(1, 0, 1, 0, 0, 100);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 1, (i == 5) ? 100 : 0, 100);
        settle();
        chk("stop_then_to_state", int'(state), 3);
        chk("stop_then_to_flag", int'(stop_flag), 1);
        chk("stop_then_to_hit", int'(hit_cycle), 5);

        // Match and timeout on the same edge
        cyc(1, 1, 0, 0, 0, 100);
        cyc(1, 0, 1, 0, 0, 100);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 1, (i == 19) ? 100 : 0, 100);
        settle();
        chk("simul_state", int'(state), 3);
        chk("simul_flags", int'({stop_flag, stop_pulse, finish}), 7);
        chk("simul_hit", int'(hit_cycle), 19);

        // Clear beats start in FINISHED; matches in IDLE are ignored
        cyc(1, 1, 1, 0, 0, 100);
        settle();
        chk("clear_state", int'(state), 0);
        chk("clear_flags", int'({stop_flag, stop_pulse, finish, hit_cycle}), 0);
        cyc(1, 0, 0, 1, 100, 100);
        settle();
        chk("idle_match_ignored", int'(stop_flag), 0);

        // Reset in STOPPED, then rearm
        cyc(1, 0, 1, 0, 0, 100);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, (i == 2) ? 100 : 0, 100);
        cyc(0, 0, 0, 1, 100, 100);
        settle();
        chk("midreset_state", int'(state), 0);
        chk("midreset_outs", int'({stop_flag, stop_pulse, finish, hit_cycle}), 0);
        cyc(1, 0, 1, 0, 0, 100);
        settle();
        chk("rearm_state", int'(state), 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int unsigned thr;
            int unsigned val;
            thr = $urandom_range(0, 7);
            val = ($urandom_range(0, 9) == 0) ? thr : $urandom_range(8, 300);
            cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1, val, thr);
        end
        idle_cyc();

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) settle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stop_detector.md
STOP_DETECTOR -- requirements
Module: stop_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of monitored value and threshold.
REQ-002 SHALL have parameter TIMEOUT, default 20, cycles in ARMED/STOPPED before forced finish (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse, arms the monitor.
REQ-006 SHALL have port clear  input  1  synchronous soft clear, returns to IDLE.
REQ-007 SHALL have port acc_valid  input  1  upstream accumulator sample valid.
REQ-008 SHALL have port acc_val  input  WIDTH  upstream accumulator value.
REQ-009 SHALL have port threshold  input  WIDTH  stop value; sampled only when a match is evaluated.
REQ-010 SHALL have port stop_flag  output  1  sticky, set on threshold match.
REQ-011 SHALL have port stop_pulse  output  1  one-cycle pulse on the cycle stop_flag rises.
REQ-012 SHALL have port finish  output  1  sticky, set on timeout.
REQ-013 SHALL have port hit_cycle  output  16  cycle count captured at match.
REQ-014 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-015 SHALL implement FSM states IDLE=0, ARMED=1, STOPPED=2, FINISHED=3.
REQ-016 SHALL move IDLE->ARMED on start=1, clearing the cycle counter to 0 on that edge.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL, in ARMED, detect a match when acc_valid=1 and acc_val==threshold (exact equality, unsigned).
REQ-019 SHALL, on a match edge, set stop_flag=1, drive stop_pulse=1 for exactly the next cycle, load hit_cycle with the counter value of the matching cycle, and go to STOPPED.
REQ-020 SHALL ignore further matches in STOPPED and FINISHED (no re-pulse, hit_cycle held).
REQ-021 SHALL increment the 16-bit cycle counter by 1 each cycle in ARMED and STOPPED; counter held in IDLE and FINISHED.
REQ-022 SHALL, when counter==TIMEOUT-1 in ARMED or STOPPED, set finish=1 and go to FINISHED on that edge.
REQ-023 SHALL, if a match and the timeout occur in the same cycle, set stop_flag, stop_pulse and hit_cycle as for a match and go to FINISHED with finish=1.
REQ-024 SHALL remain in FINISHED until clear or reset.
REQ-025 SHALL, on clear=1, go to IDLE and zero stop_flag, stop_pulse, finish, hit_cycle and counter on that edge, from any state.
REQ-026 SHALL give clear priority over start and over match/timeout in the same cycle.
REQ-027 SHALL register all outputs (no combinational path input->output).

Reset
REQ-028 SHALL, on a clk edge with rst_n=0, set state=IDLE, stop_flag=0, stop_pulse=0, finish=0, hit_cycle=0, counter=0, overriding all other inputs.
REQ-029 SHALL treat reset mid-operation (ARMED/STOPPED) identically to REQ-028; no flag survives.

Verification
REQ-030 SHALL verify normal stop: threshold=100, start, then acc_valid=1 each cycle with acc_val=0,10,20,...; match on 11th sample (val 100) -> stop_pulse one cycle, stop_flag=1, hit_cycle=10, state=2.
REQ-031 SHALL verify timeout: threshold=100, acc_val stays 0 -> finish=1, state=3 after exactly 20 cycles in ARMED, stop_flag=0.
REQ-032 SHALL verify stop then timeout: match at counter 5 -> state 2, then finish=1 when counter reaches 19, stop_flag still 1, hit_cycle=5.
REQ-033 SHALL verify simultaneous match and timeout: acc_val==threshold first at counter 19 -> stop_flag=1, finish=1, hit_cycle=19, state=3 on same edge.
REQ-034 SHALL verify clear/start priority and gating: clear and start together in FINISHED -> IDLE, all flags 0; acc_valid match while IDLE -> no stop_flag.
REQ-035 SHALL verify reset mid-run: rst_n=0 for one edge in STOPPED -> all outputs 0, state=0; subsequent start rearms normally.
